pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter REG_W, default 3: register-index width, giving 8 architectural registers; R0 reads as zero.
REQ-002 Parameter CNT_W, default 16: width of the performance counters.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 id_valid  input  1  the ID stage holds a real instruction.
REQ-006 id_rs1, id_rs2  input  REG_W each  ID source register indices.
REQ-007 id_use1, id_use2  input  1 each  the ID instruction reads rs1 / rs2.
REQ-008 id_rd  input  REG_W  ID destination register index.
REQ-009 id_wr  input  1  the ID instruction writes id_rd.
REQ-010 id_load  input  1  the ID instruction is a load.
REQ-011 ex_br_taken  input  1  the branch in the EX stage resolved as taken this cycle.
REQ-012 pc_write, ifid_write  output  1 each  enables for the PC and IF/ID registers.
REQ-013 idex_bubble  output  1  forces a NOP into the ID/EX register.
REQ-014 ifid_flush  output  1  squashes the IF/ID register contents.
REQ-015 pc_sel_branch  output  1  PC takes the branch target.
REQ-016 fwd_a, fwd_b  output  2 each  ALU operand source: 00 = register file, 01 = EX/MEM, 10 = MEM/WB, 11 = WB.
REQ-017 stall_cnt, flush_cnt  output  CNT_W each  saturating event counters.
REQ-018 state  output  2  current controller state.

Function
REQ-019 Shadow pipeline: three internal stages, EX, MEM and WB, each holding {valid, rd, wr, load}.
REQ-020 Shadow advance: the stages shift every cycle, ID to EX, EX to MEM, MEM to WB.
REQ-021 Shadow EX entry: when idex_bubble = 1, EX receives valid = 0.
REQ-022 Tracking rule: only entries with valid = 1, wr = 1 and rd != 0 take part in hazard checks; any entry with rd = 0 is ignored.
REQ-023 Load-use hazard: the hazard exists when id_valid = 1, EX is a load, and EX.rd matches an ID source that is in use.
REQ-024 Load-use response: for exactly one cycle, pc_write = 0, ifid_write = 0 and idex_bubble = 1.
REQ-025 Stall length: the next cycle re-evaluates, and the load is then in MEM, so the stall never exceeds one cycle per load.
REQ-026 Forwarding priority, per operand: EX (non-load) match gives 01, else MEM match gives 10, else WB match gives 11, else 00; the youngest producer wins.
REQ-027 Forwarding outputs are combinational from the ID fields and the shadow state, and are valid in the same cycle.
REQ-028 Branch flush: when ex_br_taken = 1, pc_sel_branch = 1, ifid_flush = 1 and idex_bubble = 1 in that cycle, so the two younger instructions are squashed.
REQ-029 Flush priority: ex_br_taken together with a load-use hazard means the flush wins; pc_write = 1, the stall is not counted, and the ID instruction is discarded.
REQ-030 State machine, states RUN = 0, STALL = 1, FLUSH = 2.
REQ-031 STALL transition: any state goes to STALL on a load-use hazard without a flush.
REQ-032 FLUSH transition: any state goes to FLUSH on ex_br_taken.
REQ-033 RUN transition: any state goes to RUN otherwise.
REQ-034 The state register reflects the previous cycle's event.
REQ-035 Consecutive branches: FLUSH followed by FLUSH is legal, and each occurrence is counted.
REQ-036 stall_cnt increments once per stall cycle and flush_cnt once per flush cycle.
REQ-037 Both counters saturate at 2^CNT_W - 1 and never wrap.
REQ-038 Idle outputs, with no hazard and no flush: pc_write = 1, ifid_write = 1, idex_bubble = 0, ifid_flush = 0, pc_sel_branch = 0.

Reset
REQ-039 While rst = 0: all shadow valid bits clear, state = RUN, both counters = 0, fwd_a = fwd_b = 00, pc_write = ifid_write = 1, and the bubble/flush/pc_sel outputs = 0.
REQ-040 Reset asserted mid-stall or mid-flush abandons the event immediately, and no counter increments for that cycle.
REQ-041 The first edge after rst rises behaves as RUN with an empty shadow pipeline.

Structure
REQ-042 Package pipe_ctrl_pkg holds the fwd_t encodings (FWD_RF, FWD_EXMEM, FWD_MEMWB, FWD_WB), the ctrl_state_t enum, and the shadow-entry struct.
REQ-043 One sub-module, hz_shadow_stage, is instantiated three times; it is a single {valid, rd, wr, load} register with an asynchronous active-low clear.
REQ-044 The per-operand forwarding select is a function in the package, not a module.

Verification
REQ-045 Load-use: R3 = load in EX, then ID "add R4, R3, R1" -> one cycle of pc_write = 0 and idex_bubble = 1; next cycle fwd_a = 10; stall_cnt = 1.
REQ-046 Back-to-back ALU ops: "add R2" followed by "sub R5, R2, R2" -> no stall, fwd_a = fwd_b = 01.
REQ-047 Priority: R2 written in EX, MEM and WB with ID reading R2 -> fwd = 01; after EX is bubbled, fwd = 10.
REQ-048 R0: a producer writing R0 followed by a consumer of R0 -> fwd = 00, no stall.
REQ-049 Branch with load-use in the same cycle -> ifid_flush = 1, pc_sel_branch = 1, pc_write = 1; state = FLUSH next cycle; flush_cnt = 1, stall_cnt = 0.
REQ-050 Counter saturation with CNT_W = 4: 20 consecutive taken branches -> flush_cnt holds at 15.
REQ-051 Reset mid-stall: rst = 0 during a stall cycle -> outputs reach their reset values with no clock edge; stall_cnt = 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// controller states, shadow-stage entries and the operand forwarding function.
package pipe_ctrl_pkg;

  // Wide enough for any supported register-index width; narrower indices are zero-extended.
  localparam int RD_MAX_W = 8;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10,
    FWD_WB    = 2'b11
  } fwd_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                wr;
    logic                load;
  } shadow_t;

  function automatic logic tracked(shadow_t e);
    return e.valid && e.wr && (e.rd != '0);
  endfunction

  // Youngest producer wins; a load still in EX has no data yet.
  function automatic fwd_t fwd_sel(logic [RD_MAX_W-1:0] rs, shadow_t ex, shadow_t mem,
                                   shadow_t wb);
    if (tracked(ex) && !ex.load && (ex.rd == rs))
      return FWD_EXMEM;
    else if (tracked(mem) && (mem.rd == rs))
      return FWD_MEMWB;
    else if (tracked(wb) && (wb.rd == rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/hz_shadow_stage.sv
// One shadow pipeline stage: a {valid, rd, wr, load} register cleared by reset.
import pipe_ctrl_pkg::*;

module hz_shadow_stage (
  input  logic    clk,
  input  logic    rst,
  input  shadow_t d,
  output shadow_t q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= '0;
    else      q <= d;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use stall, branch flush,
// operand forwarding selects and saturating stall/flush event counters.
//
//   state | meaning
//   RUN   | previous cycle had no hazard and no flush
//   STALL | previous cycle stalled for a load-use hazard
//   FLUSH | previous cycle squashed IF/ID and ID/EX for a taken branch
import pipe_ctrl_pkg::*;

module pipe_hazard_ctrl #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_wr,
  input  logic             id_load,
  input  logic             ex_br_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             pc_sel_branch,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  shadow_t             ex_d, ex_q, mem_q, wb_q;
  logic [RD_MAX_W-1:0] rs1_x, rs2_x, rd_x;
  logic                load_use, flush, stall;
  ctrl_state_t         state_q, state_d;

  always_comb begin
    rs1_x = '0;
    rs2_x = '0;
    rd_x  = '0;
    rs1_x[REG_W-1:0] = id_rs1;
    rs2_x[REG_W-1:0] = id_rs2;
    rd_x[REG_W-1:0]  = id_rd;
  end

  // Gated by reset so a taken-branch input cannot drive outputs while in reset.
  assign flush    = ex_br_taken & rst;
  assign load_use = id_valid & tracked(ex_q) & ex_q.load &
                    ((id_use1 & (ex_q.rd == rs1_x)) | (id_use2 & (ex_q.rd == rs2_x)));
  assign stall    = load_use & ~flush;

  assign pc_write      = ~stall;
  assign ifid_write    = ~stall;
  assign idex_bubble   = stall | flush;
  assign ifid_flush    = flush;
  assign pc_sel_branch = flush;

  assign fwd_a = fwd_sel(rs1_x, ex_q, mem_q, wb_q);
  assign fwd_b = fwd_sel(rs2_x, ex_q, mem_q, wb_q);

  always_comb begin
    ex_d.valid = id_valid & ~idex_bubble;
    ex_d.rd    = rd_x;
    ex_d.wr    = id_wr;
    ex_d.load  = id_load;
  end

  hz_shadow_stage u_ex  (.clk(clk), .rst(rst), .d(ex_d),  .q(ex_q));
  hz_shadow_stage u_mem (.clk(clk), .rst(rst), .d(ex_q),  .q(mem_q));
  hz_shadow_stage u_wb  (.clk(clk), .rst(rst), .d(mem_q), .q(wb_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = RUN;
    if (flush)      state_d = FLUSH;
    else if (stall) state_d = STALL;
  end

  assign state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + 1'b1;
      if (flush && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule
